alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the combinational ALU; width set by WIDTH.
- Registers every result and exchanges operands/results over valid/ready.
- Adds carry/overflow flags and an iterative shift-add multiply.
- Sits between the operand-issue stage and writeback; one operation in flight at a time.

---
 rtl/alu_pipe_if.sv | 20 ++
 rtl/alu_pipe.sv | 156 +++++++++++++++
 tb/tb_alu_pipe.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: operands flow in on
// in_valid/in_ready, registered results flow out on out_valid/out_ready.
interface alu_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             z;
  logic             c;
  logic             v;

  modport master (output in_valid, a, b, aluc, out_ready,
                  input  in_ready, out_valid, r, z, c, v);
  modport slave  (input  in_valid, a, b, aluc, out_ready,
                  output in_ready, out_valid, r, z, c, v);
endinterface

// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with carry/overflow flags. Define ALU_PIPE_MUL_EN
// to build the iterative shift-add multiplier behind opcode 1011.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic             z_q, c_q, v_q, vld_q;
  logic             accept, xfer, load;
  logic [WIDTH-1:0] res, load_r;
  logic             res_c, res_v, load_c, load_v;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   sh;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = vld_q && bus.out_ready;

  // Single-cycle datapath; shifts run one bit wider so the last bit shifted
  // out lands in the extra position (and is 0 for a zero shift amount).
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    wide  = '0;
    sh    = bus.a[SHW-1:0];
    case (bus.aluc[1:0])
      2'b00: begin
        if (!bus.aluc[2]) begin
          wide  = {1'b0, bus.a} + {1'b0, bus.b};
          res   = wide[WIDTH-1:0];
          res_c = wide[WIDTH];
          res_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (res[WIDTH-1] != bus.a[WIDTH-1]);
        end else begin
          res   = bus.a - bus.b;
          res_c = bus.a < bus.b;
          res_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (res[WIDTH-1] != bus.a[WIDTH-1]);
        end
      end
      2'b01: res = bus.aluc[2] ? (bus.a | bus.b) : (bus.a & bus.b);
      2'b10: res = bus.aluc[2] ? (bus.b << (WIDTH / 2)) : (bus.a ^ bus.b);
      default: begin
        case (bus.aluc[3:2])
          2'b00: begin
            wide  = {1'b0, bus.b} << sh;
            res   = wide[WIDTH-1:0];
            res_c = wide[WIDTH];
          end
          2'b01: begin
            wide  = {bus.b, 1'b0} >> sh;
            res   = wide[WIDTH:1];
            res_c = wide[0];
          end
          2'b11: begin
            wide  = $signed({bus.b, 1'b0}) >>> sh;
            res   = wide[WIDTH:1];
            res_c = wide[0];
          end
          default: res = '0;  // MUL slot: zero result when no multiplier is built
        endcase
      end
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [SHW-1:0]   cnt;
  logic             is_mul, mul_done;

  assign is_mul  = (bus.aluc == 4'b1011);
  assign acc_nxt = mcand[0] ? acc + mplier : acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_done  = 1'b0;
    case (state)
      IDLE: if (accept && is_mul) state_nxt = MUL;
      MUL: begin
        // Final iteration folds straight into the output register.
        if (cnt == SHW'(WIDTH - 1)) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE && accept && is_mul) begin
      mcand  <= bus.a;
      mplier <= bus.b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mplier <= mplier << 1;
      mcand  <= mcand >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign bus.in_ready = (state == IDLE) && (!vld_q || bus.out_ready) && !rst;
  assign load         = (accept && !is_mul) || mul_done;
  assign load_r       = mul_done ? acc_nxt : res;
  assign load_c       = mul_done ? 1'b0 : res_c;
  assign load_v       = mul_done ? 1'b0 : res_v;
`else
  assign bus.in_ready = (!vld_q || bus.out_ready) && !rst;
  assign load         = accept;
  assign load_r       = res;
  assign load_c       = res_c;
  assign load_v       = res_v;
`endif

  // A load on the transfer edge replaces the departing result with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      r_q   <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (load) begin
      vld_q <= 1'b1;
      r_q   <= load_r;
      z_q   <= (load_r == '0);
      c_q   <= load_c;
      v_q   <= load_v;
    end else if (xfer) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.r         = r_q;
  assign bus.z         = z_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=32; MUL checks follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;
  localparam int W = 32;
  typedef struct packed {logic [W-1:0] r; logic z; logic c; logic v;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_pipe_if #(.WIDTH(W)) bus();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   stalls = 0;

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v);
    exp_t e;
    e.r = r; e.z = (r == '0); e.c = c; e.v = v;
    return e;
  endfunction

  // Reference for random add/sub/logic ops using 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          s;
    longint unsigned u;
    logic [W-1:0]    r;
    logic            c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      4'b0000: begin
        u = longint'(x) + longint'(y);
        s = longint'($signed(x)) + longint'($signed(y));
        r = u[W-1:0]; c = u[W];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r = x - y; c = (x < y);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0001: r = x & y;
      4'b0101: r = x | y;
      default: r = x ^ y;
    endcase
    return mk(r, c, v);
  endfunction

  task automatic monitor();
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got = {bus.r, bus.z, bus.c, bus.v};
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL result_unexpected got r=%h z=%b c=%b v=%b", bus.r, bus.z, bus.c, bus.v);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL result got r=%h z=%b c=%b v=%b required r=%h z=%b c=%b v=%b",
                     got.r, got.z, got.c, got.v, e.r, e.z, e.c, e.v);
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int n = 0;
    bus.in_valid = 1'b1; bus.aluc = op; bus.a = x; bus.b = y;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    stalls += n;
    if (bus.in_ready) sb.push_back(e);
    else begin
      total++; bad++;
      $display("FAIL accept_timeout op=%b in_ready=0 required 1", op);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.aluc = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.r, bus.z, bus.c, bus.v, bus.in_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got vld=%b r=%h z=%b c=%b v=%b rdy=%b required all 0",
               bus.out_valid, bus.r, bus.z, bus.c, bus.v, bus.in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    issue(4'b0000, 32'd10, 32'd3, mk(32'd13, 1'b0, 1'b0));
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL add_latency out_valid=%b required 1", bus.out_valid);
    end
    @(posedge clk); #1;
    issue(4'b0000, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b0, 1'b1));
    issue(4'b0000, 32'hFFFF_FFFF, 32'd1, mk(32'h0, 1'b1, 1'b0));
    issue(4'b1000, 32'd1, 32'd1, mk(32'd2, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_sub_logic();
    bus.out_ready = 1'b1;
    issue(4'b0100, 32'd3, 32'd3, mk(32'd0, 1'b0, 1'b0));
    issue(4'b0100, 32'd3, 32'd10, mk(32'hFFFF_FFF9, 1'b1, 1'b0));
    issue(4'b1100, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
    issue(4'b0001, 32'hF0F0, 32'h0FF0, mk(32'h00F0, 1'b0, 1'b0));
    issue(4'b1101, 32'hF0F0, 32'h0FF0, mk(32'hFFF0, 1'b0, 1'b0));
    issue(4'b0010, 32'hF0F0, 32'h0FF0, mk(32'hFF00, 1'b0, 1'b0));
    issue(4'b0110, 32'hFFFF, 32'h1234, mk(32'h1234_0000, 1'b0, 1'b0));
    issue(4'b1110, 32'h0, 32'hABCD_0001, mk(32'h0001_0000, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_shift();
    bus.out_ready = 1'b1;
    issue(4'b1111, 32'd4, 32'h8000_0000, mk(32'hF800_0000, 1'b0, 1'b0));
    issue(4'b0111, 32'd4, 32'h8000_0000, mk(32'h0800_0000, 1'b0, 1'b0));
    issue(4'b0011, 32'd1, 32'h8000_0000, mk(32'h0, 1'b1, 1'b0));
    issue(4'b0011, 32'd0, 32'd5, mk(32'd5, 1'b0, 1'b0));
    issue(4'b0111, 32'd1, 32'd3, mk(32'd1, 1'b1, 1'b0));
    issue(4'b0011, 32'd33, 32'd1, mk(32'd2, 1'b0, 1'b0));
    issue(4'b1111, 32'd1, 32'h8000_0001, mk(32'hC000_0000, 1'b1, 1'b0));
    drain();
  endtask

  task automatic test_mul();
    bus.out_ready = 1'b1;
`ifdef ALU_PIPE_MUL_EN
    begin
      int n = 0;
      int rdy_hi = 0;
      issue(4'b1011, 32'd10, 32'd3, mk(32'd30, 1'b0, 1'b0));
      @(negedge clk);
      while (!bus.out_valid && n < 100) begin
        if (bus.in_ready !== 1'b0) rdy_hi++;
        n++;
        @(negedge clk);
      end
      total++;
      if (n != W) begin
        bad++; $display("FAIL mul_latency busy_cycles=%0d required %0d", n, W);
      end
      total++;
      if (rdy_hi != 0) begin
        bad++; $display("FAIL mul_in_ready high_cycles=%0d required 0", rdy_hi);
      end
      @(posedge clk); #1;
      issue(4'b1011, 32'hFFFF_FFFF, 32'd2, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
      issue(4'b1011, 32'h0001_0001, 32'h0001_0001, mk(32'h0002_0001, 1'b0, 1'b0));
      drain();
    end
`else
    issue(4'b1011, 32'd10, 32'd3, mk(32'd0, 1'b0, 1'b0));
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL mul_off_latency out_valid=%b required 1", bus.out_valid);
    end
    @(posedge clk); #1;
    drain();
`endif
  endtask

  task automatic test_backpressure();
    int s0;
    bus.out_ready = 1'b0;
    issue(4'b0000, 32'd5, 32'd6, mk(32'd11, 1'b0, 1'b0));
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.r, bus.z, bus.c, bus.v, bus.in_ready} !== {1'b1, 32'd11, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold got vld=%b r=%h z=%b c=%b v=%b rdy=%b required vld=1 r=0000000b zcv=000 rdy=0",
                 bus.out_valid, bus.r, bus.z, bus.c, bus.v, bus.in_ready);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    s0 = stalls;
    issue(4'b0001, 32'hF0F0, 32'h0FF0, mk(32'h00F0, 1'b0, 1'b0));
    total++;
    if (stalls != s0) begin
      bad++; $display("FAIL bp_same_edge stalls=%0d required 0", stalls - s0);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.r !== 32'h00F0) begin
      bad++; $display("FAIL bp_next vld=%b r=%h required vld=1 r=000000f0", bus.out_valid, bus.r);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[5];
    logic [W-1:0] x, y;
    logic [3:0] op;
    int s0;
    ops = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010};
    bus.out_ready = 1'b1;
    s0 = stalls;
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 4)];
      x = $urandom;
      y = (i % 6 == 0) ? 32'h8000_0000 : $urandom;
      if (i % 7 == 0) x = 32'h7FFF_FFFF;
      issue(op, x, y, model(op, x, y));
    end
    drain();
    total++;
    if (stalls != s0) begin
      bad++; $display("FAIL b2b_throughput stalls=%0d required 0", stalls - s0);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
`ifdef ALU_PIPE_MUL_EN
    bus.out_ready = 1'b1;
    issue(4'b1011, 32'd7, 32'd9, mk(32'd63, 1'b0, 1'b0));
`else
    bus.out_ready = 1'b0;
    issue(4'b0000, 32'd7, 32'd9, mk(32'd16, 1'b0, 1'b0));
`endif
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got %b required 0", bus.in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.r, bus.z, bus.c, bus.v, bus.in_ready} !== {37'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_mid_outputs vld=%b r=%h z=%b c=%b v=%b rdy=%b required 0s rdy=1",
               bus.out_valid, bus.r, bus.z, bus.c, bus.v, bus.in_ready);
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_mid_no_result valid_cycles=%0d required 0", seen);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(4'b0000, 32'd1, 32'd1, mk(32'd2, 1'b0, 1'b0));
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_add();
    test_sub_logic();
    test_shift();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
